// File: rtl/acl_pkg.sv
// rtl/acl_pkg.sv - shared constants, state type and axis slicing for the accelerometer filter
package acl_pkg;

    localparam int ACL_AXES   = 3;
    localparam int ACL_AXIS_W = 5;

    typedef logic [0:0] acl_state_t;
    localparam acl_state_t ST_FILL = 1'b0;
    localparam acl_state_t ST_RUN  = 1'b1;

    // Axis 0 (X) sits in the most significant slice of the packed word.
    function automatic int axis_lsb(input int axis, input int axes, input int axis_w);
        return (axes - 1 - axis) * axis_w;
    endfunction

endpackage

// File: rtl/acl_axis_avg.sv
// rtl/acl_axis_avg.sv - one axis moving-average window with running sum and registered average
module acl_axis_avg
    import acl_pkg::*;
#(
    parameter int AXIS_W     = ACL_AXIS_W,
    parameter int DEPTH_LOG2 = 2,
    parameter int PTR_W      = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     accept,
    input  logic [PTR_W-1:0]         wr_ptr,
    input  logic                     load_avg,
    input  logic signed [AXIS_W-1:0] sample,
    output logic signed [AXIS_W-1:0] avg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = AXIS_W + DEPTH_LOG2;

    logic signed [AXIS_W-1:0] win [DEPTH];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;

    assign sum_next = sum + SUM_W'(sample) - SUM_W'(win[wr_ptr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            avg <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else if (flush) begin
            sum <= '0;
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        end else begin
            if (accept) begin
                sum         <= sum_next;
                win[wr_ptr] <= sample;
            end
            // Arithmetic shift floors toward minus infinity; the quotient always fits AXIS_W.
            if (load_avg) avg <= AXIS_W'(sum >>> DEPTH_LOG2);
        end
    end

endmodule

// File: rtl/acl_motion_filter.sv
// rtl/acl_motion_filter.sv - per-axis averaging, warm-up FSM and rate-limited dead-zone stepping
module acl_motion_filter
    import acl_pkg::*;
#(
    parameter int AXES        = ACL_AXES,
    parameter int AXIS_W      = ACL_AXIS_W,
    parameter int DEPTH_LOG2  = 2,
    parameter int DEADZONE    = 2,
    parameter int TICK_CYCLES = 1666667
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset_n,
    input  logic [AXES*AXIS_W-1:0]   acl_data,
    input  logic                     sample_valid,
    input  logic                     flush,
    output logic [AXES*AXIS_W-1:0]   avg_data,
    output logic                     avg_valid,
    output logic [AXES-1:0]          step_pos,
    output logic [AXES-1:0]          step_neg,
    output logic                     step_valid
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PTR_W  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam logic signed [AXIS_W:0] DZ_P = (AXIS_W+1)'(DEADZONE);
    localparam logic signed [AXIS_W:0] DZ_N = -DZ_P;

    acl_state_t        state;
    logic [CNT_W-1:0]  fill_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic              accept;
    logic              accept_q;
    logic              load_avg;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_wrap;
    logic [AXES-1:0]   pos_cmp;
    logic [AXES-1:0]   neg_cmp;

    assign accept    = sample_valid & ~flush;
    assign load_avg  = accept_q & (state == ST_RUN) & ~flush;
    assign tick_wrap = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        localparam int LSB = axis_lsb(i, AXES, AXIS_W);
        logic signed [AXIS_W-1:0] avg_i;
        logic signed [AXIS_W:0]   avg_x;

        acl_axis_avg #(
            .AXIS_W     (AXIS_W),
            .DEPTH_LOG2 (DEPTH_LOG2),
            .PTR_W      (PTR_W)
        ) u_avg (
            .clk      (CLK100MHZ),
            .rst_n    (reset_n),
            .flush    (flush),
            .accept   (accept),
            .wr_ptr   (wr_ptr),
            .load_avg (load_avg),
            .sample   (acl_data[LSB +: AXIS_W]),
            .avg      (avg_i)
        );

        assign avg_data[LSB +: AXIS_W] = avg_i;
        assign avg_x                   = (AXIS_W+1)'(avg_i);
        assign pos_cmp[AXES-1-i]       = avg_x > DZ_P;
        assign neg_cmp[AXES-1-i]       = avg_x < DZ_N;
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            wr_ptr    <= '0;
            accept_q  <= 1'b0;
            avg_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            wr_ptr    <= '0;
            accept_q  <= 1'b0;
            avg_valid <= 1'b0;
        end else begin
            accept_q  <= sample_valid;
            avg_valid <= load_avg;
            if (sample_valid) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                if (state == ST_FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == CNT_W'(DEPTH - 1)) state <= ST_RUN;
                end
            end
        end
    end

    // Steps sample the registered average as it stood before this edge.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt   <= '0;
            step_valid <= 1'b0;
            step_pos   <= '0;
            step_neg   <= '0;
        end else begin
            tick_cnt   <= tick_wrap ? '0 : tick_cnt + 1'b1;
            step_valid <= tick_wrap;
            if (flush) begin
                step_pos <= '0;
                step_neg <= '0;
            end else if (tick_wrap) begin
                step_pos <= (state == ST_RUN) ? pos_cmp : '0;
                step_neg <= (state == ST_RUN) ? neg_cmp : '0;
            end
        end
    end

endmodule

// File: tb/tb_acl_motion_filter.sv
// tb/tb_acl_motion_filter.sv - self-checking bench for acl_motion_filter against a window model
module tb_acl_motion_filter;

    localparam int AXES  = 3;
    localparam int W     = 5;
    localparam int DEPTH = 4;
    localparam int DZ    = 2;
    localparam int TICK  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [AXES*W-1:0] acl_data;
    logic              sample_valid;
    logic              flush;
    logic [AXES*W-1:0] avg_data;
    logic              avg_valid;
    logic [AXES-1:0]   step_pos;
    logic [AXES-1:0]   step_neg;
    logic              step_valid;

    acl_motion_filter #(
        .AXES(AXES), .AXIS_W(W), .DEPTH_LOG2(2), .DEADZONE(DZ), .TICK_CYCLES(TICK)
    ) dut (
        .CLK100MHZ    (clk),
        .reset_n      (reset_n),
        .acl_data     (acl_data),
        .sample_valid (sample_valid),
        .flush        (flush),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .step_pos     (step_pos),
        .step_neg     (step_neg),
        .step_valid   (step_valid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int              win_q [AXES][$];
    int              n_acc;
    int              cyc_cnt;
    bit              pend;
    int              pend_avg [AXES];
    int              e_avg [AXES];
    bit              e_avg_valid;
    bit              e_step_valid;
    logic [AXES-1:0] e_pos;
    logic [AXES-1:0] e_neg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AXES*W-1:0] pack(input int x, input int y, input int z);
        return {x[W-1:0], y[W-1:0], z[W-1:0]};
    endfunction

    function automatic int field(input logic [AXES*W-1:0] d, input int i);
        logic signed [W-1:0] f;
        f = d[(AXES-1-i)*W +: W];
        return int'(f);
    endfunction

    function automatic int floor_div(input int s);
        if (s >= 0) return s / DEPTH;
        return -((-s + DEPTH - 1) / DEPTH);
    endfunction

    function automatic logic [AXES*W-1:0] exp_avg_vec();
        logic [AXES*W-1:0] v;
        for (int i = 0; i < AXES; i++) v[(AXES-1-i)*W +: W] = e_avg[i][W-1:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < AXES; i++) begin
            win_q[i].delete();
            e_avg[i] = 0;
        end
        n_acc = 0; cyc_cnt = 0; pend = 0;
        e_avg_valid = 0; e_step_valid = 0; e_pos = '0; e_neg = '0;
    endtask

    task automatic model_edge(input bit sv, input logic [AXES*W-1:0] d, input bit fl);
        bit tick;
        int s;
        cyc_cnt++;
        tick         = (cyc_cnt % TICK) == 0;
        e_step_valid = tick;
        e_avg_valid  = pend && !fl;
        if (fl) begin
            e_pos = '0; e_neg = '0;
        end else if (tick) begin
            for (int i = 0; i < AXES; i++) begin
                e_pos[AXES-1-i] = (n_acc >= DEPTH) && (e_avg[i] > DZ);
                e_neg[AXES-1-i] = (n_acc >= DEPTH) && (e_avg[i] < -DZ);
            end
        end
        if (e_avg_valid) for (int i = 0; i < AXES; i++) e_avg[i] = pend_avg[i];
        if (fl) begin
            for (int i = 0; i < AXES; i++) win_q[i].delete();
            n_acc = 0; pend = 0;
        end else if (sv) begin
            n_acc++;
            pend = n_acc >= DEPTH;
            for (int i = 0; i < AXES; i++) begin
                win_q[i].push_back(field(d, i));
                if (win_q[i].size() > DEPTH) void'(win_q[i].pop_front());
                s = 0;
                foreach (win_q[i][k]) s += win_q[i][k];
                pend_avg[i] = floor_div(s);
            end
        end else begin
            pend = 0;
        end
    endtask

    task automatic cycle(input bit sv, input logic [AXES*W-1:0] d, input bit fl);
        sample_valid = sv; acl_data = d; flush = fl;
        @(posedge clk); #1;
        model_edge(sv, d, fl);
        check("avg_valid", avg_valid, e_avg_valid);
        check("avg_data", avg_data, exp_avg_vec());
        check("step_valid", step_valid, e_step_valid);
        check("step_pos", step_pos, e_pos);
        check("step_neg", step_neg, e_neg);
        sample_valid = 0; flush = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_avg_valid"}, avg_valid, 0);
        check({tag, "_avg_data"}, avg_data, 0);
        check({tag, "_step_valid"}, step_valid, 0);
        check({tag, "_step_pos"}, step_pos, 0);
        check({tag, "_step_neg"}, step_neg, 0);
    endtask

    task automatic wait_tick(input string tag);
        bit seen = 0;
        for (int k = 0; k < TICK + 4 && !seen; k++) begin
            cycle(0, '0, 0);
            seen = step_valid;
        end
        check({tag, "_tick_seen"}, seen, 1);
    endtask

    task automatic feed(input int x, input int y, input int z, input int n);
        for (int k = 0; k < n; k++) cycle(1, pack(x, y, z), 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        check_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            sample_valid = 1'($urandom_range(0, 1));
            acl_data     = (AXES*W)'($urandom_range(0, 32767));
            flush        = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_zero("in_reset");
        end
        sample_valid = 0; flush = 0;
        reset_n = 1;
        model_reset();
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++)
            cycle($urandom_range(0, 2) != 0, (AXES*W)'($urandom_range(0, 32767)),
                  $urandom_range(0, 39) == 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; sample_valid = 0; flush = 0; acl_data = '0;
        @(posedge clk); #1;
        do_reset();

        // first tick exactly TICK cycles after release, steps still 0
        for (int k = 0; k < TICK - 1; k++) cycle(0, '0, 0);
        check("first_tick_early", step_valid, 0);
        cycle(0, '0, 0);
        check("first_tick", step_valid, 1);
        check("first_tick_pos", step_pos, 0);

        feed(8, 0, 0, 3);
        check("fill_no_valid", avg_valid, 0);
        feed(8, 0, 0, 1);
        check("fill_4th_no_valid_yet", avg_valid, 0);
        cycle(0, '0, 0);
        check("first_avg_valid", avg_valid, 1);
        check("first_avg_data", avg_data, 15'b01000_00000_00000);

        feed(-8, 0, 0, 2);
        cycle(0, '0, 0);
        check("cancel_avg", avg_data, 0);
        feed(3, 0, 0, 4);
        cycle(0, '0, 0);
        wait_tick("x_plus3");
        check("x_plus3_pos", step_pos, 3'b100);
        check("x_plus3_neg", step_neg, 3'b000);

        feed(2, 0, 0, 4);
        cycle(0, '0, 0);
        wait_tick("x_plus2");
        check("x_plus2_pos", step_pos, 3'b000);

        feed(-3, 0, 0, 4);
        cycle(0, '0, 0);
        wait_tick("x_minus3");
        check("x_minus3_neg", step_neg, 3'b100);

        feed(0, -2, 0, 4);
        cycle(0, '0, 0);
        wait_tick("y_minus2");
        check("y_minus2_neg", step_neg, 3'b000);
        check("y_minus2_pos", step_pos, 3'b000);

        cycle(0, '0, 1);
        feed(-1, 0, 0, 1);
        feed(0, 0, 0, 3);
        cycle(0, '0, 0);
        check("floor_avg", avg_data, 15'b11111_00000_00000);
        wait_tick("floor");
        check("floor_neg", step_neg, 3'b000);

        feed(3, 0, 0, 4);
        cycle(0, '0, 0);
        wait_tick("pre_flush");
        check("pre_flush_pos", step_pos, 3'b100);
        feed(5, 5, 5, 2);
        cycle(1, pack(7, 7, 7), 1);
        check("flush_pos_clear", step_pos, 0);
        check("flush_neg_clear", step_neg, 0);
        feed(1, 1, 1, 3);
        cycle(0, '0, 0);
        check("flush_3_no_valid", avg_valid, 0);
        feed(1, 1, 1, 1);
        cycle(0, '0, 0);
        check("flush_4_valid", avg_valid, 1);
        check("flush_4_data", avg_data, pack(1, 1, 1));

        random_run(400);
        do_reset();
        check_zero("after_mid_reset");
        random_run(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
